pattern_detector_6: RTL
=======================

# pattern_detector_6

Serial-input 6-bit pattern detector. It shifts a qualified bit stream into a 6-bit window and feeds the window and a programmable pattern register to the team's 6-bit equality comparator, `Equal_array_6`. It registers the comparator's result as a match pulse and keeps a saturating count of matches. It sits directly upstream of the comparator, turning a serial stream into the two parallel operands that the comparator consumes.

## Interface
Parameters:
- OVERLAP, default 1: 1 lets matches overlap; 0 clears the window after each match.
- CNT_W, default 8: width of the match counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- load_pat  input  1  captures `pat` and flushes the window.
- pat  input  6  pattern value, sampled when `load_pat` = 1.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  qualifies `bit_in`; one bit accepted per cycle.
- clr_cnt  input  1  clears `match_count`.
- window  output  6  current shift window; the newest bit is in bit 0.
- armed  output  1  1 when the window holds 6 valid bits.
- match  output  1  one-cycle registered match pulse.
- match_count  output  CNT_W  number of matches, saturating.

## Operation
- State:
  - `pat_r[5:0]`
  - `window[5:0]`
  - `fill[2:0]`, range 0..6, saturates at 6
  - `match` register
  - `match_count`
- `armed` = (`fill` == 6). It is combinational from `fill`.
- Accepted bit (`bit_valid` = 1 and `load_pat` = 0):
  - `nxt_win` = {`window[4:0]`, `bit_in`}
  - `nxt_fill` = min(`fill` + 1, 6)
- Compare: `Equal_array_6` compares `nxt_win` with `pat_r`. `hit` = `equ` AND (`nxt_fill` == 6) AND accepted bit.
- On `hit`:
  - `match` <= 1.
  - `match_count` increments, saturating at 2^CNT_W − 1.
  - If OVERLAP = 0: `window` <= 0 and `fill` <= 0 instead of `nxt_win` and `nxt_fill`.
  - If OVERLAP = 1: `window` <= `nxt_win` and `fill` <= `nxt_fill`.
- No accepted bit: `window` and `fill` hold, and `match` <= 0.
- `load_pat` = 1:
  - `pat_r` <= `pat`, `window` <= 0, `fill` <= 0, `match` <= 0.
  - Any `bit_valid` in the same cycle is dropped.
  - `match_count` is unaffected.
- `clr_cnt` = 1: `match_count` <= 0. Clear takes priority over a same-cycle increment; the `match` pulse still fires.
- Priority, highest first: `rst`, `load_pat`, bit accept. `clr_cnt` is independent of the other controls.
- Comparison is purely bitwise equality, with no don't-care bits. A pattern of 000000 matches only after 6 real zero bits have been accepted. A zero-filled window never matches early.

## Timing
- Reset (`rst` = 1 at an edge) sets:
  - `pat_r` = 0, `window` = 0, `fill` = 0
  - `armed` = 0, `match` = 0, `match_count` = 0
- Reset mid-stream discards all partial window state.
- Latency: a bit accepted at edge t shows in `window` after edge t. `match` and the updated `match_count` for that bit also appear after edge t, one cycle after the bit is presented.
- `match` is high for exactly one cycle per `hit`. Back-to-back hits give consecutive high cycles; this is only possible with OVERLAP = 1 and a periodic pattern such as 111111.
- `bit_valid` gaps do not disturb `window` or `fill`.
- A `load_pat` pulse takes 1 cycle. The next accepted bit is the first bit of a new 6-bit fill.
- The counter saturates and never wraps. `clr_cnt` takes effect at the next edge.

## Test plan
- Reset check: assert `rst` for 2 cycles with `bit_valid` = 1 -> all outputs are 0 after the reset edges; `fill` restarts from 0 on release.
- Overlapping matches: OVERLAP = 1, `pat` = 101101, stream 1,0,1,1,0,1,1,0,1 -> `match` high after the 6th and 9th bits; `match_count` = 2.
- Non-overlapping matches: OVERLAP = 0, same pattern and stream -> `match` after the 6th bit only; `match_count` = 1; `window` = 000101 and `fill` = 3 at the end.
- Early-match suppression and gaps: `pat` = 000000, stream of four 0 bits -> no match, `armed` = 0. Then two more 0 bits interleaved with `bit_valid` = 0 gaps -> `match` after the 6th accepted bit.
- Mid-stream reload: `pat` = 111111, feed 5 ones, then `load_pat` with `pat` = 111111 and `bit_valid` = 1 in the same cycle -> that bit is dropped and `fill` = 0. Five further ones give no match; the 6th gives `match`.
- Counter saturation and clear: CNT_W = 2, OVERLAP = 1, `pat` = 111111, feed 10 ones -> `match_count` goes 1,2,3,3,3. Then `clr_cnt` in the same cycle as a `hit` -> `match` = 1 and `match_count` = 0.

Source files
------------

// File: rtl/pattern_detector_6.sv
`default_nettype none
// ============================================================================
// Module   : pattern_detector_6 (with Equal_array_6 comparator)
// Purpose  : Shifts a qualified serial stream into a 6-bit window and compares
//            it against a programmable pattern, producing a registered match
//            pulse and a saturating match count.
// Revision : 1.0 - initial release
// ============================================================================

// 6-bit bitwise equality comparator: equ = (a == b), no don't-care bits.
module Equal_array_6 (
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic       equ
);

  logic [5:0] bit_eq;

  generate
    for (genvar i = 0; i < 6; i++) begin : g_bit
      assign bit_eq[i] = ~(a[i] ^ b[i]);
    end
  endgenerate

  assign equ = &bit_eq;

endmodule

module pattern_detector_6 #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_pat,
  input  logic [5:0]       pat,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic [5:0]       window,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [2:0]       FILL_FULL    = 3'd6;
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic             CLEAR_ON_HIT = (OVERLAP == 0);

  logic [5:0] pat_r;
  logic [2:0] fill;
  logic       accept;
  logic [5:0] nxt_win;
  logic [2:0] nxt_fill;
  logic       equ;
  logic       hit;

  // A load cycle drops any bit presented alongside it.
  assign accept   = bit_valid & ~load_pat;
  assign nxt_win  = {window[4:0], bit_in};
  assign nxt_fill = (fill == FILL_FULL) ? FILL_FULL : fill + 3'd1;
  assign armed    = (fill == FILL_FULL);

  Equal_array_6 u_cmp (
    .a   (nxt_win),
    .b   (pat_r),
    .equ (equ)
  );

  // The fill gate stops a zero-flushed window from matching an all-zero pattern early.
  assign hit = equ & (nxt_fill == FILL_FULL) & accept;

  // Pattern register, shift window and fill level.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r  <= 6'd0;
      window <= 6'd0;
      fill   <= 3'd0;
    end else if (load_pat) begin
      pat_r  <= pat;
      window <= 6'd0;
      fill   <= 3'd0;
    end else if (accept) begin
      if (hit && CLEAR_ON_HIT) begin
        window <= 6'd0;
        fill   <= 3'd0;
      end else begin
        window <= nxt_win;
        fill   <= nxt_fill;
      end
    end
  end

  // One-cycle match pulse; hit is already low on load and idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      match <= 1'b0;
    end else begin
      match <= hit;
    end
  end

  // Saturating match counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
    end else if (clr_cnt) begin
      match_count <= '0;
    end else if (hit && (match_count != CNT_MAX)) begin
      match_count <= match_count + 1'b1;
    end
  end

endmodule
`default_nettype wire
